// File: rtl/rmw_mem_pkg.sv
// Shared definitions for the read-modify-write memory arbiter: operation
// encodings, controller states and default geometry.
package rmw_mem_pkg;

  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_ADDR_W = 3;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_INC   = 2'd2,
    OP_SWAP  = 2'd3
  } op_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // True for every operation that updates the addressed entry.
  function automatic logic op_writes(op_e op);
    return op != OP_READ;
  endfunction

endpackage

// File: rtl/rmw_mem_arbiter_if.sv
// Request/response bundle for both requesters plus the busy flag.
// The master side is the requester pair; the slave side is the arbiter.
interface rmw_mem_arbiter_if #(
  parameter int WIDTH = rmw_mem_pkg::DEFAULT_WIDTH
);
  import rmw_mem_pkg::*;

  logic             io_req0_valid;
  logic             io_req0_ready;
  logic [1:0]       io_req0_op;
  logic [31:0]      io_req0_addr;
  logic [WIDTH-1:0] io_req0_wdata;
  logic             io_resp0_valid;
  logic [WIDTH-1:0] io_resp0_data;

  logic             io_req1_valid;
  logic             io_req1_ready;
  logic [1:0]       io_req1_op;
  logic [31:0]      io_req1_addr;
  logic [WIDTH-1:0] io_req1_wdata;
  logic             io_resp1_valid;
  logic [WIDTH-1:0] io_resp1_data;

  logic             io_busy;

  modport master (
    output io_req0_valid, io_req0_op, io_req0_addr, io_req0_wdata,
    output io_req1_valid, io_req1_op, io_req1_addr, io_req1_wdata,
    input  io_req0_ready, io_resp0_valid, io_resp0_data,
    input  io_req1_ready, io_resp1_valid, io_resp1_data,
    input  io_busy
  );

  modport slave (
    input  io_req0_valid, io_req0_op, io_req0_addr, io_req0_wdata,
    input  io_req1_valid, io_req1_op, io_req1_addr, io_req1_wdata,
    output io_req0_ready, io_resp0_valid, io_resp0_data,
    output io_req1_ready, io_resp1_valid, io_resp1_data,
    output io_busy
  );

endinterface

// File: rtl/rmw_mem_arbiter_rr.sv
// Two-way round-robin arbiter: one-hot grant from the request vector and a
// priority pointer that flips to the other requester after each grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       ptr
);

  logic ptr_q, ptr_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and a latch is never inferred.
    grant = 2'b00;
    ptr_d = ptr_q;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
    // A grant to requester 0 hands priority to 1 and vice versa.
    if (advance && (grant != 2'b00)) begin
      ptr_d = grant[0];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of block ordering.
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/rmw_mem_arbiter.sv
// Atomic read/write/increment/swap memory shared by two requesters.
// Clears every entry after reset, then arbitrates round-robin, one op per cycle.
module rmw_mem_arbiter
  import rmw_mem_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  rmw_mem_arbiter_if.slave   bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              resp0_valid_q, resp0_valid_d;
  logic              resp1_valid_q, resp1_valid_d;
  logic [WIDTH-1:0]  resp0_data_q, resp0_data_d;
  logic [WIDTH-1:0]  resp1_data_q, resp1_data_d;

  logic [1:0]        req;
  logic [1:0]        grant;
  logic              unused_ptr;
  logic              unused_addr_bits;

  op_e               op_sel;
  logic [31:0]       addr_sel;
  logic [WIDTH-1:0]  wdata_sel;
  logic [ADDR_W-1:0] entry;
  logic [WIDTH-1:0]  old_val;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

  assign req = {bus.io_req1_valid, bus.io_req0_valid};

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .en      (state_q == RUN),
    .advance (1'b1),
    .grant   (grant),
    .ptr     (unused_ptr)
  );

  // Only the low ADDR_W address bits select an entry.
  assign unused_addr_bits = ^{bus.io_req0_addr[31:ADDR_W], bus.io_req1_addr[31:ADDR_W]};

  assign op_sel    = grant[1] ? op_e'(bus.io_req1_op) : op_e'(bus.io_req0_op);
  assign addr_sel  = grant[1] ? bus.io_req1_addr  : bus.io_req0_addr;
  assign wdata_sel = grant[1] ? bus.io_req1_wdata : bus.io_req0_wdata;
  assign entry     = addr_sel[ADDR_W-1:0];
  assign old_val   = mem_q[entry];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    wr_addr = entry;
    wr_data = wdata_sel;
    case (state_q)
      INIT: begin
        wr_en   = 1'b1;
        wr_addr = idx_q;
        wr_data = '0;
        idx_d   = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (grant != 2'b00) begin
          wr_en   = op_writes(op_sel);
          wr_data = (op_sel == OP_INC) ? old_val + WIDTH'(1) : wdata_sel;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Responses carry the pre-operation value and hold it between pulses.
  always_comb begin
    resp0_valid_d = grant[0];
    resp1_valid_d = grant[1];
    resp0_data_d  = grant[0] ? old_val : resp0_data_q;
    resp1_data_d  = grant[1] ? old_val : resp1_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= INIT;
      idx_q         <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_data_q  <= '0;
      resp1_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_data_q  <= resp0_data_d;
      resp1_data_q  <= resp1_data_d;
    end
  end

  // NOTE: the array has no reset term; the INIT sweep clears it, which keeps it mappable to plain register-file storage.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign bus.io_req0_ready  = grant[0];
  assign bus.io_req1_ready  = grant[1];
  assign bus.io_resp0_valid = resp0_valid_q;
  assign bus.io_resp1_valid = resp1_valid_q;
  assign bus.io_resp0_data  = resp0_data_q;
  assign bus.io_resp1_data  = resp1_data_q;
  assign bus.io_busy        = (state_q == INIT);

endmodule

// File: tb/tb_rmw_mem_arbiter.sv
// Directed self-checking bench for rmw_mem_arbiter: reset/INIT timing,
// each op type, address aliasing, round-robin alternation and mid-op reset.
module tb_rmw_mem_arbiter;
  import rmw_mem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rmw_mem_arbiter_if bus ();

  rmw_mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic idle_inputs();
    bus.io_req0_valid = 1'b0; bus.io_req0_op = OP_READ;
    bus.io_req0_addr  = '0;   bus.io_req0_wdata = '0;
    bus.io_req1_valid = 1'b0; bus.io_req1_op = OP_READ;
    bus.io_req1_addr  = '0;   bus.io_req1_wdata = '0;
  endtask

  // Called at a falling edge; returns at the falling edge where the response is visible.
  task automatic issue(input int r, input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic granted,
                       output logic rv, output logic [31:0] rd);
    granted = 1'b0;
    if (r == 0) begin
      bus.io_req0_valid = 1'b1; bus.io_req0_op = op;
      bus.io_req0_addr  = addr; bus.io_req0_wdata = wdata;
    end else begin
      bus.io_req1_valid = 1'b1; bus.io_req1_op = op;
      bus.io_req1_addr  = addr; bus.io_req1_wdata = wdata;
    end
    #1;
    for (int c = 0; c < 20; c++) begin
      if (((r == 0) ? bus.io_req0_ready : bus.io_req1_ready) === 1'b1) begin
        granted = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    @(negedge clk);
    if (r == 0) bus.io_req0_valid = 1'b0;
    else        bus.io_req1_valid = 1'b0;
    rv = (r == 0) ? bus.io_resp0_valid : bus.io_resp1_valid;
    rd = (r == 0) ? bus.io_resp0_data  : bus.io_resp1_data;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.io_req0_valid = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.io_req0_ready, bus.io_req1_ready, bus.io_resp0_valid, bus.io_resp1_valid} !== 4'b0000
        || bus.io_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: rdy0=%b rdy1=%b rv0=%b rv1=%b busy=%b, expected 0 0 0 0 1",
               bus.io_req0_ready, bus.io_req1_ready, bus.io_resp0_valid, bus.io_resp1_valid, bus.io_busy);
    end
    checks++;
    if (bus.io_resp0_data !== 32'h0 || bus.io_resp1_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: d0=%h d1=%h, expected 0 0", bus.io_resp0_data, bus.io_resp1_data);
    end
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if (bus.io_req0_ready !== 1'b0 || bus.io_busy !== 1'b1) begin
        errors++;
        $display("FAIL init_cycle%0d: rdy0=%b busy=%b, expected 0 1", c, bus.io_req0_ready, bus.io_busy);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (bus.io_req0_ready !== 1'b1 || bus.io_busy !== 1'b0) begin
      errors++;
      $display("FAIL ready_rise: rdy0=%b busy=%b, expected 1 0", bus.io_req0_ready, bus.io_busy);
    end
    @(negedge clk);
    bus.io_req0_valid = 1'b0;
    checks++;
    if (bus.io_resp0_valid !== 1'b1 || bus.io_resp0_data !== 32'h0) begin
      errors++;
      $display("FAIL first_read: rv=%b data=%h, expected 1 00000000", bus.io_resp0_valid, bus.io_resp0_data);
    end
  endtask

  task automatic test_read_all(input string tag);
    logic g, rv;
    logic [31:0] rd;
    for (int a = 0; a < 8; a++) begin
      issue(0, OP_READ, 32'(a), 32'hFFFF_FFFF, g, rv, rd);
      checks++;
      if (!g || rv !== 1'b1 || rd !== 32'h0) begin
        errors++;
        $display("FAIL %s_read%0d: granted=%b rv=%b data=%h, expected 1 1 00000000", tag, a, g, rv, rd);
      end
    end
  endtask

  task automatic test_write_alias();
    logic [1:0]  ops [4] = '{OP_WRITE, OP_READ, OP_READ, OP_READ};
    logic [31:0] adr [4] = '{32'd5, 32'd5, 32'h0000_000D, 32'hFFFF_FFF5};
    logic [31:0] exp [4] = '{32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    logic g, rv;
    logic [31:0] rd;
    for (int i = 0; i < 4; i++) begin
      issue(0, ops[i], adr[i], 32'hDEAD_BEEF, g, rv, rd);
      checks++;
      if (!g || rv !== 1'b1 || rd !== exp[i]) begin
        errors++;
        $display("FAIL write_alias%0d: granted=%b rv=%b data=%h, expected 1 1 %h", i, g, rv, rd, exp[i]);
      end
    end
  endtask

  task automatic test_inc_wrap();
    int          req [5] = '{0, 0, 0, 1, 0};
    logic [1:0]  ops [5] = '{OP_WRITE, OP_INC, OP_READ, OP_INC, OP_READ};
    logic [31:0] adr [5] = '{32'd6, 32'd6, 32'd6, 32'h0000_000E, 32'd6};
    logic [31:0] exp [5] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1};
    logic g, rv;
    logic [31:0] rd;
    for (int i = 0; i < 5; i++) begin
      issue(req[i], ops[i], adr[i], 32'hFFFF_FFFF, g, rv, rd);
      checks++;
      if (!g || rv !== 1'b1 || rd !== exp[i]) begin
        errors++;
        $display("FAIL inc_wrap%0d: granted=%b rv=%b data=%h, expected 1 1 %h", i, g, rv, rd, exp[i]);
      end
      if (i == 1) begin
        @(negedge clk);
        checks++;
        if (bus.io_resp0_valid !== 1'b0 || bus.io_resp0_data !== 32'hFFFF_FFFF) begin
          errors++;
          $display("FAIL resp_hold: rv=%b data=%h, expected 0 ffffffff", bus.io_resp0_valid, bus.io_resp0_data);
        end
      end
    end
  endtask

  task automatic test_swap_then_read();
    logic g, rv;
    logic [31:0] rd;
    issue(0, OP_WRITE, 32'd3, 32'h1234_5678, g, rv, rd);
    checks++;
    if (!g || rv !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL swap_prep: granted=%b rv=%b data=%h, expected 1 1 00000000", g, rv, rd);
    end
    bus.io_req1_valid = 1'b1; bus.io_req1_op = OP_SWAP;
    bus.io_req1_addr  = 32'd3; bus.io_req1_wdata = 32'd7;
    #1;
    checks++;
    if (bus.io_req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL swap_ready: rdy1=%b, expected 1", bus.io_req1_ready);
    end
    @(negedge clk);
    bus.io_req1_valid = 1'b0;
    bus.io_req0_valid = 1'b1; bus.io_req0_op = OP_READ; bus.io_req0_addr = 32'd3;
    checks++;
    if (bus.io_resp1_valid !== 1'b1 || bus.io_resp1_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL swap_resp: rv1=%b data=%h, expected 1 12345678", bus.io_resp1_valid, bus.io_resp1_data);
    end
    #1;
    checks++;
    if (bus.io_req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL swap_read_ready: rdy0=%b, expected 1", bus.io_req0_ready);
    end
    @(negedge clk);
    bus.io_req0_valid = 1'b0;
    checks++;
    if (bus.io_resp0_valid !== 1'b1 || bus.io_resp0_data !== 32'd7 || bus.io_resp1_valid !== 1'b0) begin
      errors++;
      $display("FAIL swap_read: rv0=%b data=%h rv1=%b, expected 1 00000007 0",
               bus.io_resp0_valid, bus.io_resp0_data, bus.io_resp1_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic g, rv;
    logic [31:0] rd;
    logic [1:0]  exp_grant;
    int n0 = 0;
    int n1 = 0;
    // A lone req1 grant leaves priority with req0.
    issue(1, OP_READ, 32'd2, 32'h0, g, rv, rd);
    checks++;
    if (!g || rv !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL b2b_prep: granted=%b rv=%b data=%h, expected 1 1 00000000", g, rv, rd);
    end
    bus.io_req0_valid = 1'b1; bus.io_req0_op = OP_INC; bus.io_req0_addr = 32'd2;
    bus.io_req1_valid = 1'b1; bus.io_req1_op = OP_INC; bus.io_req1_addr = 32'd2;
    for (int i = 0; i < 10; i++) begin
      exp_grant = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++;
      if ({bus.io_req1_ready, bus.io_req0_ready} !== exp_grant) begin
        errors++;
        $display("FAIL b2b_grant%0d: ready=%b, expected %b", i,
                 {bus.io_req1_ready, bus.io_req0_ready}, exp_grant);
      end
      @(negedge clk);
      if (i == 9) begin
        bus.io_req0_valid = 1'b0;
        bus.io_req1_valid = 1'b0;
      end
      if (bus.io_resp0_valid === 1'b1) n0++;
      if (bus.io_resp1_valid === 1'b1) n1++;
      rd = exp_grant[0] ? bus.io_resp0_data : bus.io_resp1_data;
      checks++;
      if ({bus.io_resp1_valid, bus.io_resp0_valid} !== exp_grant || rd !== 32'(i)) begin
        errors++;
        $display("FAIL b2b_resp%0d: valids=%b data=%h, expected %b %h", i,
                 {bus.io_resp1_valid, bus.io_resp0_valid}, rd, exp_grant, 32'(i));
      end
    end
    checks++;
    if (n0 != 5 || n1 != 5) begin
      errors++;
      $display("FAIL b2b_counts: resp0=%0d resp1=%0d, expected 5 5", n0, n1);
    end
    issue(0, OP_READ, 32'd2, 32'h0, g, rv, rd);
    checks++;
    if (!g || rv !== 1'b1 || rd !== 32'd10) begin
      errors++;
      $display("FAIL b2b_final: granted=%b rv=%b data=%h, expected 1 1 0000000a", g, rv, rd);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    bus.io_req0_valid = 1'b1; bus.io_req0_op = OP_WRITE;
    bus.io_req0_addr  = 32'd4; bus.io_req0_wdata = 32'hAAAA_5555;
    #1;
    checks++;
    if (bus.io_req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready: rdy0=%b, expected 1", bus.io_req0_ready);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.io_resp0_valid !== 1'b0 || bus.io_busy !== 1'b1 || bus.io_req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: rv0=%b busy=%b rdy0=%b, expected 0 1 0",
               bus.io_resp0_valid, bus.io_busy, bus.io_req0_ready);
    end
    reset = 1'b0;
    bus.io_req0_op = OP_READ;
    c = 0;
    while (c < 20) begin
      #1;
      if (bus.io_req0_ready === 1'b1) break;
      c++;
      @(negedge clk);
    end
    checks++;
    if (c != 8) begin
      errors++;
      $display("FAIL midrst_init_len: cycles=%0d, expected 8", c);
    end
    @(negedge clk);
    bus.io_req0_valid = 1'b0;
    checks++;
    if (bus.io_resp0_valid !== 1'b1 || bus.io_resp0_data !== 32'h0) begin
      errors++;
      $display("FAIL midrst_read4: rv=%b data=%h, expected 1 00000000", bus.io_resp0_valid, bus.io_resp0_data);
    end
    test_read_all("midrst");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_read_all("post_init");
    test_write_alias();
    test_inc_wrap();
    test_swap_then_read();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
